// File: rtl/proc_scheduler_pkg.sv
// Package: proc_scheduler_pkg
// Shared definitions for the round-robin process scheduler:
//   - default slot count, slot id width and PC width
//   - 3-bit FSM state encoding (IDLE=0 .. LOAD=5)
//   - helper that decodes the "switch in progress" states
package proc_scheduler_pkg;

    localparam int unsigned DefNumProc = 4;
    localparam int unsigned DefProcW   = 2;
    localparam int unsigned DefPcW     = 10;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StSave  = 3'd3,
        StPick  = 3'd4,
        StLoad  = 3'd5
    } sched_state_e;

    // Fetch/PC must stay frozen for the whole switch sequence.
    function automatic logic is_switching(sched_state_e st);
        return (st == StDrain) || (st == StSave) || (st == StPick) || (st == StLoad);
    endfunction

endpackage

// File: rtl/proc_scheduler_rr_picker.sv
// Module: proc_scheduler_rr_picker
// Combinational round-robin find-next over the live-slot bitmap.
// Ports:
//   valid    in  NUM_PROC  live-slot bitmap
//   start_id in  PROC_W    first slot examined; search wraps modulo NUM_PROC
//   found    out 1         some slot is live
//   next_id  out PROC_W    first live slot at or after start_id (wrapping)
module proc_scheduler_rr_picker
    import proc_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PROC = DefNumProc,
    parameter int unsigned PROC_W   = DefProcW
) (
    input  logic [NUM_PROC-1:0] valid,
    input  logic [PROC_W-1:0]   start_id,
    output logic                found,
    output logic [PROC_W-1:0]   next_id
);

    int unsigned idx;

    always_comb begin
        found   = 1'b0;
        next_id = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            idx = 32'(start_id) + i;
            if (idx >= NUM_PROC) begin
                idx = idx - NUM_PROC;
            end
            if (!found && valid[idx[PROC_W-1:0]]) begin
                found   = 1'b1;
                next_id = idx[PROC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/proc_scheduler.sv
// Module: proc_scheduler
// Round-robin process scheduler. A switch (proc_swap, proc_end, or quantum expiry) stalls the
// pipeline, waits for it to drain, saves the outgoing PC (or retires the slot on proc_end),
// picks the next live slot starting after the current one, and reloads its PC.
// Configuration macro: PROC_SCHED_PREEMPT_EN builds the quantum counter and makes its expiry a
// switch trigger; without it scheduling is purely cooperative.
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   enable                        OS has handed control to the scheduler
//   proc_swap / proc_end          yield / terminate pulses from the control unit
//   proc_create/create_id/_pc     register a loaded slot and its entry PC
//   cur_pc                        resume PC of the running process
//   pipe_idle                     core drained, safe to swap
//   stall_req                     freeze fetch/PC while switching
//   pc_load / pc_next             1-cycle PC reload strobe and restored PC
//   cur_proc                      running slot
//   proc_valid                    live-slot bitmap
//   no_proc                       1-cycle pulse: nothing left to run
module proc_scheduler
    import proc_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PROC = DefNumProc,
    parameter int unsigned PROC_W   = DefProcW,
    parameter int unsigned PC_W     = DefPcW,
    parameter int unsigned QUANTUM  = 1024,
    parameter int unsigned QNT_W    = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                proc_swap,
    input  logic                proc_end,
    input  logic                proc_create,
    input  logic [PROC_W-1:0]   create_id,
    input  logic [PC_W-1:0]     create_pc,
    input  logic [PC_W-1:0]     cur_pc,
    input  logic                pipe_idle,
    output logic                stall_req,
    output logic                pc_load,
    output logic [PC_W-1:0]     pc_next,
    output logic [PROC_W-1:0]   cur_proc,
    output logic [NUM_PROC-1:0] proc_valid,
    output logic                no_proc
);

    sched_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_table_q [NUM_PROC];
    logic [PC_W-1:0]     pc_table_d [NUM_PROC];
    logic [NUM_PROC-1:0] valid_q, valid_d;
    logic [PROC_W-1:0]   cur_q, cur_d;
    logic                end_f_q, end_f_d;
    logic                expire;
    logic [PROC_W-1:0]   start_id;
    logic                pick_found;
    logic [PROC_W-1:0]   pick_id;

    // Search begins after the running slot so the running slot is considered last.
    assign start_id = (cur_q == PROC_W'(NUM_PROC - 1)) ? '0 : cur_q + 1'b1;

    proc_scheduler_rr_picker #(
        .NUM_PROC (NUM_PROC),
        .PROC_W   (PROC_W)
    ) u_picker (
        .valid    (valid_q),
        .start_id (start_id),
        .found    (pick_found),
        .next_id  (pick_id)
    );

`ifdef PROC_SCHED_PREEMPT_EN
    logic [QNT_W-1:0] qcnt_q, qcnt_d;

    assign expire = (state_q == StRun) && (qcnt_q == QNT_W'(QUANTUM - 1));

    // Holds at expiry instead of wrapping; LOAD restarts the count.
    always_comb begin
        qcnt_d = qcnt_q;
        if (state_q == StLoad) begin
            qcnt_d = '0;
        end else if ((state_q == StRun) && !expire) begin
            qcnt_d = qcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end
`else
    logic unused_qnt_cfg;

    assign expire         = 1'b0;
    assign unused_qnt_cfg = ^{QUANTUM, QNT_W};
`endif

    always_comb begin
        state_d    = state_q;
        pc_table_d = pc_table_q;
        valid_d    = valid_q;
        cur_d      = cur_q;
        end_f_d    = end_f_q;
        pc_load    = 1'b0;
        pc_next    = '0;
        no_proc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && (|valid_q)) begin
                    state_d = StPick;
                end
            end
            StRun: begin
                if (proc_swap || proc_end || expire) begin
                    // A coincident swap and end is handled as an end.
                    end_f_d = proc_end;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_idle) begin
                    state_d = StSave;
                end
            end
            StSave: begin
                if (end_f_q) begin
                    valid_d[cur_q] = 1'b0;
                end else begin
                    pc_table_d[cur_q] = cur_pc;
                end
                state_d = StPick;
            end
            StPick: begin
                if (pick_found) begin
                    cur_d   = pick_id;
                    state_d = StLoad;
                end else begin
                    no_proc = 1'b1;
                    state_d = StIdle;
                end
            end
            StLoad: begin
                pc_load = 1'b1;
                pc_next = pc_table_q[cur_q];
                state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        // The running slot cannot be overwritten while a process is active; this also keeps
        // creation from colliding with the SAVE write to the same slot.
        if (proc_create && ((state_q == StIdle) || (create_id != cur_q))) begin
            pc_table_d[create_id] = create_pc;
            valid_d[create_id]    = 1'b1;
        end
    end

    assign stall_req  = is_switching(state_q);
    assign cur_proc   = cur_q;
    assign proc_valid = valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= '0;
            cur_q   <= '0;
            end_f_q <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++) begin
                pc_table_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cur_q      <= cur_d;
            end_f_q    <= end_f_d;
            pc_table_q <= pc_table_d;
        end
    end

endmodule

// File: tb/tb_proc_scheduler.sv
// Testbench: tb_proc_scheduler
// Expected (slot, PC) pairs are queued whenever a switch is provoked and popped by a monitor on
// every pc_load strobe. Directed checks cover reset, drain stalling, reload latency, slot
// retirement, wrap-around picking, ignored out-of-RUN triggers, no_proc and reset mid-switch.
// With PROC_SCHED_PREEMPT_EN a second instance (QUANTUM=8) checks forced round-robin.
module tb_proc_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, proc_swap, proc_end, proc_create, pipe_idle;
    logic [1:0] create_id;
    logic [9:0] create_pc, cur_pc;
    logic       stall_req, pc_load, no_proc;
    logic [9:0] pc_next;
    logic [1:0] cur_proc;
    logic [3:0] proc_valid;

    always #5 clock = ~clock;

    proc_scheduler #(
        .NUM_PROC (4),
        .PROC_W   (2),
        .PC_W     (10),
        .QUANTUM  (1024),
        .QNT_W    (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .proc_swap   (proc_swap),
        .proc_end    (proc_end),
        .proc_create (proc_create),
        .create_id   (create_id),
        .create_pc   (create_pc),
        .cur_pc      (cur_pc),
        .pipe_idle   (pipe_idle),
        .stall_req   (stall_req),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .cur_proc    (cur_proc),
        .proc_valid  (proc_valid),
        .no_proc     (no_proc)
    );

`ifdef PROC_SCHED_PREEMPT_EN
    logic       p_enable = 1'b0, p_create = 1'b0;
    logic [1:0] p_create_id = '0;
    logic [9:0] p_create_pc = '0;
    logic       p_stall, p_load, p_no_proc;
    logic [9:0] p_pc_next;
    logic [1:0] p_cur;
    logic [3:0] p_valid;

    proc_scheduler #(
        .NUM_PROC (4),
        .PROC_W   (2),
        .PC_W     (10),
        .QUANTUM  (8),
        .QNT_W    (3)
    ) dut_pre (
        .clock       (clock),
        .reset       (reset),
        .enable      (p_enable),
        .proc_swap   (1'b0),
        .proc_end    (1'b0),
        .proc_create (p_create),
        .create_id   (p_create_id),
        .create_pc   (p_create_pc),
        .cur_pc      (10'd123),
        .pipe_idle   (1'b1),
        .stall_req   (p_stall),
        .pc_load     (p_load),
        .pc_next     (p_pc_next),
        .cur_proc    (p_cur),
        .proc_valid  (p_valid),
        .no_proc     (p_no_proc)
    );
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   load_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_push(input logic [1:0] id, input logic [9:0] pc);
        exp_t e;
        e.id = id;
        e.pc = pc;
        sb_q.push_back(e);
    endtask

    // Returns on the first RUN cycle after the next pc_load strobe.
    task automatic wait_load(input string tag);
        int n0;
        int k;
        n0 = load_cnt;
        k  = 0;
        while ((load_cnt == n0) && (k < 40)) begin
            tick();
            k++;
        end
        if (load_cnt == n0) check({tag, "_timeout"}, 32'(load_cnt - n0), 32'd1);
    endtask

    task automatic do_switch(input logic swap, input logic endp, input logic [9:0] pc_in,
                             input logic [1:0] exp_id, input logic [9:0] exp_pc,
                             input string tag);
        cur_pc = pc_in;
        sb_push(exp_id, exp_pc);
        proc_swap = swap;
        proc_end  = endp;
        tick();
        proc_swap = 1'b0;
        proc_end  = 1'b0;
        wait_load(tag);
    endtask

    task automatic create(input logic [1:0] id, input logic [9:0] pc);
        proc_create = 1'b1;
        create_id   = id;
        create_pc   = pc;
        tick();
        proc_create = 1'b0;
    endtask

    always @(negedge clock) begin
        if (pc_load) begin
            exp_t e;
            load_cnt++;
            if (sb_q.size() == 0) begin
                check("load_unexpected", 32'(pc_load), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("load_pc", 32'(pc_next), 32'(e.pc));
                check("load_id", 32'(cur_proc), 32'(e.id));
            end
        end
    end

    initial begin
        int n0;
        reset = 1'b1; enable = 1'b0; proc_swap = 1'b0; proc_end = 1'b0; proc_create = 1'b0;
        create_id = '0; create_pc = '0; cur_pc = '0; pipe_idle = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_load", 32'(pc_load), 32'd0);
        check("rst_pc_next", 32'(pc_next), 32'd0);
        check("rst_cur", 32'(cur_proc), 32'd0);
        check("rst_valid", 32'(proc_valid), 32'd0);
        check("rst_no_proc", 32'(no_proc), 32'd0);

        create(2'd0, 10'd10);
        create(2'd1, 10'd20);
        create(2'd2, 10'd30);
        check("created_valid", 32'(proc_valid), 32'b0111);

        // First pick starts after slot 0.
        sb_push(2'd1, 10'd20);
        enable = 1'b1;
        wait_load("start");
        check("run_stall", 32'(stall_req), 32'd0);
        check("run_cur", 32'(cur_proc), 32'd1);

        // Yield with the pipeline busy for several cycles.
        cur_pc = 10'd25; pipe_idle = 1'b0; proc_swap = 1'b1;
        tick();
        proc_swap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("drain_stall", 32'(stall_req), 32'd1);
            tick();
        end
        check("drain_hold", 32'(pc_load), 32'd0);
        sb_push(2'd2, 10'd30);
        pipe_idle = 1'b1;
        tick();
        check("lat_save", 32'(pc_load), 32'd0);
        tick();
        check("lat_pick", 32'(pc_load), 32'd0);
        tick();
        check("lat_load", 32'(pc_load), 32'd1);
        tick();

        // Slot 2 ends; search wraps to slot 0.
        do_switch(1'b0, 1'b1, 10'd33, 2'd0, 10'd10, "end2");
        check("end2_valid", 32'(proc_valid), 32'b0011);
        // Slot 1 resumes at the PC saved on its yield.
        do_switch(1'b1, 1'b0, 10'd15, 2'd1, 10'd25, "resume1");
        // Swap and end together behave as an end.
        do_switch(1'b1, 1'b1, 10'd77, 2'd0, 10'd15, "swap_end");
        check("swap_end_valid", 32'(proc_valid), 32'b0001);
        // Single live slot is re-picked at its saved PC.
        do_switch(1'b1, 1'b0, 10'd17, 2'd0, 10'd17, "single");

        // Create while running, then switch to it.
        create(2'd3, 10'd40);
        check("run_create_valid", 32'(proc_valid), 32'b1001);
        do_switch(1'b1, 1'b0, 10'd19, 2'd3, 10'd40, "to3");

        // proc_end during DRAIN must not retire the slot.
        cur_pc = 10'd41;
        sb_push(2'd0, 10'd19);
        proc_swap = 1'b1;
        tick();
        proc_swap = 1'b0;
        proc_end  = 1'b1;
        tick();
        proc_end  = 1'b0;
        wait_load("late_end");
        check("late_end_valid", 32'(proc_valid), 32'b1001);

        do_switch(1'b0, 1'b1, 10'd5, 2'd3, 10'd41, "end0");
        check("end0_valid", 32'(proc_valid), 32'b1000);

        // Last live slot ends.
        proc_end = 1'b1;
        tick();
        proc_end = 1'b0;
        tick();
        tick();
        check("no_proc_pulse", 32'(no_proc), 32'd1);
        tick();
        check("no_proc_clear", 32'(no_proc), 32'd0);
        check("idle_stall", 32'(stall_req), 32'd0);
        check("idle_valid", 32'(proc_valid), 32'd0);

        // IDLE with enable low does not start a process.
        enable = 1'b0;
        create(2'd2, 10'd50);
        n0 = load_cnt;
        repeat (4) tick();
        check("disabled_no_load", 32'(load_cnt), 32'(n0));
        check("disabled_stall", 32'(stall_req), 32'd0);
        sb_push(2'd2, 10'd50);
        enable = 1'b1;
        wait_load("reenable");

        // Reset during DRAIN abandons the switch.
        pipe_idle = 1'b0;
        proc_swap = 1'b1;
        tick();
        proc_swap = 1'b0;
        check("pre_rst_stall", 32'(stall_req), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_load", 32'(pc_load), 32'd0);
        check("midrst_valid", 32'(proc_valid), 32'd0);
        check("midrst_cur", 32'(cur_proc), 32'd0);
        check("midrst_no_proc", 32'(no_proc), 32'd0);
        reset = 1'b0;
        pipe_idle = 1'b1;
        enable = 1'b0;
        tick();

`ifdef PROC_SCHED_PREEMPT_EN
        begin
            logic [1:0] exp_ids [4];
            logic [9:0] exp_pcs [4];
            int         last_t;
            int         t;
            int         k;
            exp_ids = '{2'd1, 2'd0, 2'd1, 2'd0};
            exp_pcs = '{10'd200, 10'd100, 10'd123, 10'd123};
            p_create = 1'b1; p_create_id = 2'd0; p_create_pc = 10'd100;
            tick();
            p_create_id = 2'd1; p_create_pc = 10'd200;
            tick();
            p_create = 1'b0;
            p_enable = 1'b1;
            t = 0;
            last_t = 0;
            for (int n = 0; n < 4; n++) begin
                k = 0;
                tick();
                t++;
                while (!p_load && (k < 40)) begin
                    tick();
                    t++;
                    k++;
                end
                check("pre_load", 32'(p_load), 32'd1);
                check("pre_id", 32'(p_cur), 32'(exp_ids[n]));
                check("pre_pc", 32'(p_pc_next), 32'(exp_pcs[n]));
                if (n > 0) check("pre_period", 32'(t - last_t), 32'd12);
                last_t = t;
            end
        end
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
